// File: rtl/dcmi_pkg.sv
// Shared definitions for the DCMI receiver: FSM encoding, synchronizer depth
// and the CRC-8 helper used when DCMI_RX_CRC_EN is defined.
package dcmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RECV  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam int         SYNC_STAGES = 2;

  // CRC-8, MSB of the data byte shifted in first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/dcmi_rx_sync.sv
// Brings the DCMI bus into the CLK domain and derives the byte-sample strobe
// (DCLK rise with DSYNC high) and the frame-end pulse (DSYNC fall).
module dcmi_rx_sync
  import dcmi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       dsync_i,
  input  logic       dclk_i,
  output logic       sample_o,
  output logic [7:0] data_o,
  output logic       dsync_o,
  output logic       frame_end_o
);

  // Index SYNC_STAGES-1 is the last synchronizer flop; index SYNC_STAGES is the edge-detect stage.
  logic [SYNC_STAGES:0]        dclk_q, dclk_d;
  logic [SYNC_STAGES:0]        dsync_q, dsync_d;
  logic [SYNC_STAGES-1:0][7:0] data_q, data_d;

  always_comb begin
    dclk_d  = {dclk_q[SYNC_STAGES-1:0], dclk_i};
    dsync_d = {dsync_q[SYNC_STAGES-1:0], dsync_i};
    data_d  = {data_q[SYNC_STAGES-2:0], data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q  <= '0;
      dsync_q <= '0;
      data_q  <= '0;
    end else begin
      dclk_q  <= dclk_d;
      dsync_q <= dsync_d;
      data_q  <= data_d;
    end
  end

  // DATA and DSYNC are taken from the stage that lines up with the DCLK edge.
  assign data_o      = data_q[SYNC_STAGES-1];
  assign dsync_o     = dsync_q[SYNC_STAGES-1];
  assign sample_o    = dclk_q[SYNC_STAGES-1] & ~dclk_q[SYNC_STAGES] & dsync_q[SYNC_STAGES-1];
  assign frame_end_o = dsync_q[SYNC_STAGES] & ~dsync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dcmi_receiver.sv
// DCMI frame receiver: captures one frame into a byte buffer that is drained
// through an RD/DO port. `define DCMI_RX_CRC_EN to add the CRC-8 output.
module dcmi_receiver
  import dcmi_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [7:0]  DATA,
  input  logic        DSYNC,
  input  logic        DCLK,
  input  logic        RD,
  input  logic        ARM,
  output logic [7:0]  DO,
  output logic        EMPTY,
  output logic [AW:0] LEN,
  output logic        DONE,
  output logic        OVF,
`ifdef DCMI_RX_CRC_EN
  output logic [7:0]  CRC,
`endif
  output logic [1:0]  STATE_DBG,
  output logic        BUSY
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic       sample, frame_end, sync_dsync;
  logic [7:0] sync_data;

  dcmi_rx_sync u_sync (
    .clk        (CLK),
    .rst_n      (nRST),
    .data_i     (DATA),
    .dsync_i    (DSYNC),
    .dclk_i     (DCLK),
    .sample_o   (sample),
    .data_o     (sync_data),
    .dsync_o    (sync_dsync),
    .frame_end_o(frame_end)
  );

  rx_state_e   state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] len_q, len_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        seen_low_q, seen_low_d;
  logic [7:0]  do_q, do_d;
  logic        wr_en, empty;
  logic [7:0]  mem [DEPTH];
`ifdef DCMI_RX_CRC_EN
  logic [7:0]  crc_q, crc_d;
`endif

  // Pointers never run more than DEPTH apart within a frame, so the extra
  // top bit of each distinguishes full from empty; the low AW bits address the RAM.
  assign empty = (count_q == rd_ptr_q);

  // Read port: RD is a one-cycle pop, honoured only when !EMPTY. DO always
  // shows the byte at the read pointer one cycle after it becomes available.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    seen_low_d = seen_low_q;
    wr_en      = 1'b0;
    do_d       = empty ? do_q : mem[rd_ptr_q[AW-1:0]];
`ifdef DCMI_RX_CRC_EN
    crc_d      = crc_q;
`endif
    if (ARM) begin
      state_d    = ST_ARMED;
      count_d    = '0;
      rd_ptr_d   = '0;
      len_d      = '0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
      seen_low_d = ~sync_dsync;
`ifdef DCMI_RX_CRC_EN
      crc_d      = '0;
`endif
    end else begin
      if (RD && !empty) rd_ptr_d = rd_ptr_q + ONE;
      unique case (state_q)
        ST_ARMED: begin
          // A frame already running at ARM time is skipped until DSYNC drops.
          if (!sync_dsync) seen_low_d = 1'b1;
          if (sample && seen_low_q) begin
            state_d = ST_RECV;
            wr_en   = 1'b1;
          end
        end
        ST_RECV: begin
          if (frame_end) begin
            len_d   = count_q;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (sample) begin
            if (count_q == FULL_CNT) ovf_d = 1'b1;
            else                     wr_en = 1'b1;
          end
        end
        default: ;
      endcase
      if (wr_en) begin
        count_d = count_q + ONE;
`ifdef DCMI_RX_CRC_EN
        crc_d   = crc8_update(crc_q, sync_data);
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      seen_low_q <= 1'b0;
      do_q       <= '0;
`ifdef DCMI_RX_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      seen_low_q <= seen_low_d;
      do_q       <= do_d;
`ifdef DCMI_RX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[count_q[AW-1:0]] <= sync_data;
  end

  assign DO        = do_q;
  assign EMPTY     = empty;
  assign LEN       = len_q;
  assign DONE      = done_q;
  assign OVF       = ovf_q;
  assign BUSY      = (state_q == ST_RECV);
  assign STATE_DBG = state_q;
`ifdef DCMI_RX_CRC_EN
  assign CRC       = crc_q;
`endif

endmodule

// File: tb/tb_dcmi_receiver.sv
// Directed bench for dcmi_receiver (DEPTH=16): bytes expected in the buffer are
// queued as they are driven and popped by a monitor on every accepted RD.
module tb_dcmi_receiver;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic        CLK = 1'b0;
  logic        nRST, DSYNC, DCLK, RD, ARM;
  logic [7:0]  DATA;
  logic [7:0]  DO;
  logic        EMPTY, DONE, OVF, BUSY;
  logic [AW:0] LEN;
  logic [1:0]  STATE_DBG;
`ifdef DCMI_RX_CRC_EN
  logic [7:0]  CRC;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_buf[32];

  dcmi_receiver #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .DATA(DATA), .DSYNC(DSYNC), .DCLK(DCLK),
    .RD(RD), .ARM(ARM), .DO(DO), .EMPTY(EMPTY), .LEN(LEN), .DONE(DONE),
    .OVF(OVF),
`ifdef DCMI_RX_CRC_EN
    .CRC(CRC),
`endif
    .STATE_DBG(STATE_DBG), .BUSY(BUSY)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_arm();
    ARM = 1'b1;
    tick(1);
    ARM = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit store);
    DATA = b;
    DCLK = 1'b0;
    tick(2);
    DCLK = 1'b1;
    if (store) exp_q.push_back(b);
    tick(2);
  endtask

  task automatic frame_start();
    DSYNC = 1'b1;
    tick(2);
  endtask

  task automatic frame_end();
    DCLK = 1'b0;
    tick(2);
    DSYNC = 1'b0;
    tick(8);
  endtask

  // Sends frame_buf[0..n-1]; only the first n_store bytes are expected in the buffer.
  task automatic send_frame(input int n, input int n_store);
    frame_start();
    for (int i = 0; i < n; i++) send_byte(frame_buf[i], i < n_store);
    frame_end();
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin
      RD = 1'b1;
      tick(1);
      RD = 1'b0;
      tick(1);
    end
  endtask

  // Scoreboard monitor: every accepted pop must present the next queued byte.
  always @(negedge CLK) begin
    if (nRST && RD && !EMPTY) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got 0x%0h with no byte expected", DO);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (DO !== e) begin
          failures++;
          $display("FAIL sb_data: got 0x%0h expected 0x%0h", DO, e);
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; DATA = '0; DSYNC = 1'b0; DCLK = 1'b0; RD = 1'b0; ARM = 1'b0;
    tick(3);
    chk("rst_do", DO, 8'h00);
    chk("rst_empty", EMPTY, 1);
    chk("rst_len", LEN, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_state", STATE_DBG, 0);
    nRST = 1'b1;
    tick(2);

    // Basic 4-byte frame
    pulse_arm();
    chk("arm_state", STATE_DBG, 1);
    frame_buf[0] = 8'h11; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33; frame_buf[3] = 8'h44;
    send_frame(4, 4);
    chk("t1_done", DONE, 1);
    chk("t1_len", LEN, 4);
    chk("t1_ovf", OVF, 0);
    chk("t1_busy", BUSY, 0);
    chk("t1_state", STATE_DBG, 3);
    chk("t1_empty_before", EMPTY, 0);
    read_n(4);
    chk("t1_empty_after", EMPTY, 1);

    // ARM while a frame is already running: that frame is skipped
    frame_start();
    send_byte(8'h55, 0);
    pulse_arm();
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    frame_end();
    chk("t2_still_armed", STATE_DBG, 1);
    chk("t2_empty_skip", EMPTY, 1);
    frame_buf[0] = 8'h01; frame_buf[1] = 8'h02; frame_buf[2] = 8'h03;
    send_frame(3, 3);
    chk("t2_len", LEN, 3);
    chk("t2_done", DONE, 1);
    read_n(3);
    chk("t2_empty", EMPTY, 1);

    // Overflow: 20 bytes into a 16-byte buffer
    pulse_arm();
    for (int i = 0; i < 20; i++) frame_buf[i] = 8'(i);
    send_frame(20, 16);
    chk("t3_ovf", OVF, 1);
    chk("t3_len", LEN, 16);
    chk("t3_done", DONE, 1);
    chk("t3_full_not_empty", EMPTY, 0);
    read_n(16);
    chk("t3_empty", EMPTY, 1);

    // ARM after 5 bytes discards the partial frame
    pulse_arm();
    chk("t4_ovf_cleared", OVF, 0);
    frame_start();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1);
    chk("t4_busy", BUSY, 1);
    pulse_arm();
    chk("t4_state", STATE_DBG, 1);
    chk("t4_done", DONE, 0);
    chk("t4_len", LEN, 0);
    chk("t4_empty", EMPTY, 1);
    for (int i = 5; i < 9; i++) send_byte(8'hC0 + 8'(i), 0);
    frame_end();
    frame_buf[0] = 8'hA0; frame_buf[1] = 8'hA5; frame_buf[2] = 8'h5A;
    send_frame(3, 3);
    chk("t4_next_len", LEN, 3);
    read_n(3);

    // Reset in the middle of a frame
    pulse_arm();
    frame_start();
    send_byte(8'hE1, 1);
    send_byte(8'hE2, 1);
    nRST = 1'b0;
    tick(2);
    exp_q.delete();
    chk("t5_do", DO, 8'h00);
    chk("t5_empty", EMPTY, 1);
    chk("t5_len", LEN, 0);
    chk("t5_done", DONE, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_state", STATE_DBG, 0);
    nRST = 1'b1;
    send_byte(8'hE3, 0);
    frame_end();
    frame_buf[0] = 8'hF0; frame_buf[1] = 8'hF1;
    send_frame(2, 0);
    chk("t5_no_capture_empty", EMPTY, 1);
    chk("t5_no_capture_done", DONE, 0);
    chk("t5_idle", STATE_DBG, 0);

`ifdef DCMI_RX_CRC_EN
    pulse_arm();
    chk("crc_cleared", CRC, 8'h00);
    for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
    send_frame(9, 9);
    chk("crc_len", LEN, 9);
    chk("crc_value", CRC, 8'hF4);
    read_n(9);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
